decimal_feeder: RTL

Upstream stage for the 4-digit decimal TM1637 driver. Accepts binary values from application logic at any rate, saturates them to the 4-digit range, and holds only the newest value. It issues exactly one `data_latch` pulse per display frame, and only while the driver is idle, so it never interrupts a frame in progress. It also re-sends the last value periodically so the display recovers from glitches or power loss.

---
 rtl/decimal_pkg.sv | 10 +
 rtl/decimal_feeder_if.sv | 25 ++
 rtl/decimal_feeder_refresh_timer.sv | 25 ++
 rtl/decimal_feeder.sv | 112 +++++++++++
 4 files changed

// File: rtl/decimal_pkg.sv
// Shared constants for the decimal display path: value width, saturation ceiling, feeder FSM encoding.
package decimal_pkg;
   localparam int DISP_W      = 14;
   localparam int MAX_DISPLAY = 9999;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_LATCH     = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;
endpackage

// File: rtl/decimal_feeder_if.sv
// Value input and driver handshake bundle between application, feeder and decimal driver.
interface decimal_feeder_if #(
   parameter int VALUE_W = 16
);
   import decimal_pkg::*;

   logic               value_valid;
   logic [VALUE_W-1:0] value;
   logic               value_ready;
   logic               disp_busy;
   logic               disp_latch;
   logic [DISP_W-1:0]  disp_data;
   logic               pending;
   logic               overflow;

   modport master (
      output value_valid, value, disp_busy,
      input  value_ready, disp_latch, disp_data, pending, overflow
   );

   modport slave (
      input  value_valid, value, disp_busy,
      output value_ready, disp_latch, disp_data, pending, overflow
   );
endinterface

// File: rtl/decimal_feeder_refresh_timer.sv
// Loadable down-counter; load wins over decrement, o_zero flags an expired interval.
module refresh_timer #(
   parameter int W        = 24,
   parameter int LOAD_VAL = 12_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_zero
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= W'(LOAD_VAL);
      end else if (i_load) begin
         r_cnt <= W'(LOAD_VAL);
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/decimal_feeder.sv
// Saturating latest-wins feeder for the decimal driver: one latch per frame, only while the driver is idle.
// Latch follows an accept by one cycle; never back-pressures; retries frames the driver fails to acknowledge.
module decimal_feeder #(
   parameter int VALUE_W        = 16,
   parameter int MAX_DISPLAY    = decimal_pkg::MAX_DISPLAY,
   parameter int REFRESH_CYCLES = 12_000_000,
   parameter int ACK_TIMEOUT    = 4
) (
   input  logic             clk,
   input  logic             rst,
   decimal_feeder_if.slave  bus
);
   import decimal_pkg::*;

   localparam int TMR_W = (REFRESH_CYCLES < 2) ? 1 : $clog2(REFRESH_CYCLES + 1);
   localparam int ACK_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [VALUE_W-1:0] MAX_V    = VALUE_W'(MAX_DISPLAY);
   localparam logic [ACK_W-1:0]   ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic               REFRESH_EN = (REFRESH_CYCLES != 0);

   logic [1:0]        r_state;
   logic              r_latch;
   logic [DISP_W-1:0] r_data;
   logic [DISP_W-1:0] r_hold;
   logic              r_pending;
   logic              r_over;
   logic [ACK_W-1:0]  r_ack;

   logic              w_over;
   logic [DISP_W-1:0] w_sat;
   logic              w_tmr_zero;
   logic              w_tmr_load;
   logic              w_tmr_en;
   logic              w_refresh_due;

   // Full-width compare so large inputs never alias into the 14-bit range.
   assign w_over = (bus.value > MAX_V);
   assign w_sat  = w_over ? DISP_W'(MAX_DISPLAY) : bus.value[DISP_W-1:0];

   assign w_tmr_load    = (r_state == S_WAIT_DONE) && !bus.disp_busy;
   assign w_tmr_en      = (r_state == S_IDLE) && !r_pending && !w_tmr_zero;
   assign w_refresh_due = REFRESH_EN && (r_state == S_IDLE) && !r_pending &&
                          w_tmr_zero && !bus.disp_busy;

   refresh_timer #(
      .W        (TMR_W),
      .LOAD_VAL (REFRESH_CYCLES)
   ) u_refresh_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_tmr_load),
      .i_en   (w_tmr_en),
      .o_zero (w_tmr_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_latch   <= 1'b0;
         r_data    <= '0;
         r_hold    <= '0;
         r_pending <= 1'b1;
         r_over    <= 1'b0;
         r_ack     <= '0;
      end else begin
         r_latch <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_pending && !bus.disp_busy) begin
                  r_latch   <= 1'b1;
                  r_data    <= r_hold;
                  r_pending <= 1'b0;
                  r_state   <= S_LATCH;
               end else if (w_refresh_due) begin
                  r_latch <= 1'b1;
                  r_state <= S_LATCH;
               end
            end
            S_LATCH: begin
               r_ack   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (bus.disp_busy) begin
                  r_state <= S_WAIT_DONE;
               end else begin
                  r_ack <= r_ack + 1'b1;
                  if (r_ack == ACK_LAST) begin
                     r_pending <= 1'b1;
                     r_state   <= S_IDLE;
                  end
               end
            end
            default: begin
               if (!bus.disp_busy) r_state <= S_IDLE;
            end
         endcase
         // An accept overrides the pending clear above, so a value arriving with a latch gets its own frame.
         if (bus.value_valid) begin
            r_hold    <= w_sat;
            r_pending <= 1'b1;
            r_over    <= w_over;
         end
      end
   end

   assign bus.value_ready = 1'b1;
   assign bus.disp_latch  = r_latch;
   assign bus.disp_data   = r_data;
   assign bus.pending     = r_pending;
   assign bus.overflow    = r_over;
endmodule
